// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus monitor: classifies each completed bus cycle and queues one
// {type, addr, data} record per cycle in a show-ahead FIFO with drop accounting.
module z80_bus_tracer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clr_ovf,
    input  logic                     m1_n,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic [15:0]              A,
    input  logic [7:0]               di,
    input  logic [7:0]               dout,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [2:0]               rec_type,
    output logic [15:0]              rec_addr,
    output logic [7:0]               rec_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [2:0] T_OPF = 3'd0, T_MRD = 3'd1, T_MWR = 3'd2,
                           T_IRD = 3'd3, T_IWR = 3'd4, T_INTA = 3'd5;

    typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;
    state_t state, nxt;

    logic       m1, mreq, iorq, rd, wr;
    logic       act, cyc_start, same;
    logic [2:0] typ;
    logic [7:0] sdata;
    logic       prev_act;
    logic [2:0] prev_type;
    logic       commit, latch, reload;

    logic [2:0]  cap_type,  push_type;
    logic [15:0] cap_addr,  push_addr;
    logic [7:0]  cap_data,  push_data;
    logic        push_q;

    assign m1   = ~m1_n;
    assign mreq = ~mreq_n;
    assign iorq = ~iorq_n;
    assign rd   = ~rd_n;
    assign wr   = ~wr_n;

    always_comb begin
        act = 1'b1;
        typ = T_OPF;
        if (!rfsh_n)              act = 1'b0;
        else if (m1 && iorq)      typ = T_INTA;
        else if (m1 && mreq && rd) typ = T_OPF;
        else if (mreq && rd)      typ = T_MRD;
        else if (mreq && wr)      typ = T_MWR;
        else if (!m1 && iorq && rd) typ = T_IRD;
        else if (iorq && wr)      typ = T_IWR;
        else                      act = 1'b0;
        sdata = (typ == T_MWR || typ == T_IWR || typ == T_INTA) ? dout : di;
    end

    // A cycle starts only on its first active sample, so enable rising mid-cycle is ignored.
    assign cyc_start = act && (!prev_act || typ != prev_type);
    assign same      = act && typ == cap_type;

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            SYNC:    if (!act) nxt = IDLE;
            IDLE:    if (cyc_start && enable) nxt = ACTIVE;
            ACTIVE:  if (!same) nxt = (cyc_start && enable) ? ACTIVE : IDLE;
            default: nxt = SYNC;
        endcase
    end

    always_comb begin
        commit = (state == ACTIVE) && !same;
        reload = (state == ACTIVE) && same;
        latch  = (state == IDLE || commit) && cyc_start && enable;
    end

    // Commit goes through a one-stage register so a back-to-back latch cannot clobber it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_act  <= 1'b0;
            prev_type <= '0;
            cap_type  <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            push_q    <= 1'b0;
            push_type <= '0;
            push_addr <= '0;
            push_data <= '0;
        end else begin
            prev_act  <= act;
            prev_type <= typ;
            push_q    <= commit;
            if (commit) begin
                push_type <= cap_type;
                push_addr <= cap_addr;
                push_data <= cap_data;
            end
            if (latch) begin
                cap_type <= typ;
                cap_addr <= A;
                cap_data <= sdata;
            end else if (reload) begin
                cap_data <= sdata;
            end
        end
    end

    logic [2:0]  mem_type [DEPTH];
    logic [15:0] mem_addr [DEPTH];
    logic [7:0]  mem_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic pop, accept, drop;

    assign rec_valid = level != '0;
    assign pop       = rec_valid && rec_ready;
    assign accept    = push_q && (level != FULL_LVL || pop);
    assign drop      = push_q && !accept;
    assign rec_type  = mem_type[rd_ptr];
    assign rec_addr  = mem_addr[rd_ptr];
    assign rec_data  = mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_type[i] <= '0;
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_type[wr_ptr] <= push_type;
                mem_addr[wr_ptr] <= push_addr;
                mem_data[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves exactly that one drop counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: drives whole bus cycles and checks every clock
// against a queue-based record/FIFO model derived from the cycle list.
module tb_z80_bus_tracer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int T_IDLE = 6, T_RFSH = 7;

    logic clk = 1'b0;
    logic reset, enable, clr_ovf, rec_ready;
    logic m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  di, dout;
    logic        rec_valid, overflow;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data, drop_cnt;
    logic [3:0]  level;

    z80_bus_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_ovf(clr_ovf),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_addr(rec_addr), .rec_data(rec_data), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] t; logic [15:0] a; logic [7:0] d; } rec_t;
    typedef struct { int e; rec_t r; } pend_t;

    rec_t  q[$];
    pend_t pend[$];
    bit    m_ovf;
    int    m_dcnt;
    int    n_pass = 0, n_fail = 0, n_chk = 0, ecnt = 0;
    bit    rnd_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit wdat(input int t);
        return t == 2 || t == 4 || t == 5;
    endfunction

    // Model of one clock edge: pop from the head if ready, then take the scheduled push if room.
    task automatic step();
        bit pop, drop;
        @(posedge clk);
        ecnt++;
        drop = 0;
        if (reset) begin
            q.delete();
            pend.delete();
            m_ovf  = 0;
            m_dcnt = 0;
        end else begin
            pop = q.size() > 0 && rec_ready;
            if (pop) void'(q.pop_front());
            if (pend.size() > 0 && pend[0].e == ecnt) begin
                if (q.size() < DEPTH) q.push_back(pend[0].r);
                else drop = 1;
                void'(pend.pop_front());
            end
            if (clr_ovf) begin
                m_ovf  = drop;
                m_dcnt = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_dcnt < (1 << CNT_W) - 1) m_dcnt++;
            end
        end
        #1;
        chk("level", 32'(level), 32'(q.size()));
        chk("rec_valid", 32'(rec_valid), 32'(q.size() > 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
        if (q.size() > 0) begin
            chk("rec_type", 32'(rec_type), 32'(q[0].t));
            chk("rec_addr", 32'(rec_addr), 32'(q[0].a));
            chk("rec_data", 32'(rec_data), 32'(q[0].d));
        end
    endtask

    task automatic drive(input int t);
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = 6'b111111;
        case (t)
            0: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
            1: begin mreq_n = 0; rd_n = 0; end
            2: begin mreq_n = 0; wr_n = 0; end
            3: begin iorq_n = 0; rd_n = 0; end
            4: begin iorq_n = 0; wr_n = 0; end
            5: begin m1_n = 0; iorq_n = 0; end
            T_RFSH: begin mreq_n = 0; rfsh_n = 0; end
            default: ;
        endcase
    endtask

    task automatic rnd_ctl();
        if (rnd_mode) begin
            enable    = $urandom_range(0, 3) != 0;
            rec_ready = $urandom_range(0, 3) != 0;
            clr_ovf   = $urandom_range(0, 31) == 0;
        end
    endtask

    task automatic clk_drive(input int t);
        drive(t);
        rnd_ctl();
        A    = 16'($urandom);
        di   = 8'($urandom);
        dout = 8'($urandom);
        step();
    endtask

    // One bus cycle of n clocks; recorded iff enable at its first clock, with first address and last data.
    task automatic bus_cycle(input int t, input int n, input logic [15:0] addr,
                             input logic [7:0] data, input bit fixed);
        rec_t r;
        bit   en0 = 0;
        int   e0 = ecnt + 1;
        for (int i = 0; i < n; i++) begin
            drive(t);
            rnd_ctl();
            A    = (fixed || i == 0) ? addr : 16'($urandom);
            di   = 8'($urandom);
            dout = 8'($urandom);
            if (fixed) begin
                if (wdat(t)) dout = data;
                else         di   = data;
            end
            if (i == 0) en0 = enable;
            r.d = wdat(t) ? dout : di;
            step();
        end
        r.t = 3'(t);
        r.a = addr;
        if (en0) pend.push_back('{e0 + n + 1, r});
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [7:0] data);
        bus_cycle(0, 2, addr, data, 1);
        clk_drive(T_RFSH);
        clk_drive(T_RFSH);
    endtask

    initial begin
        int t, n, g, prev;
        bit nogap;
        int dsave;
        reset = 1; enable = 1; clr_ovf = 0; rec_ready = 1;
        A = 0; di = 0; dout = 0;
        drive(T_IDLE);
        step();
        step();
        chk("rst_rec_type", 32'(rec_type), 0);
        chk("rst_rec_addr", 32'(rec_addr), 0);
        chk("rst_rec_data", 32'(rec_data), 0);
        reset = 0;
        clk_drive(T_IDLE);
        clk_drive(T_IDLE);

        // Program-like sequence: fetches, a memory write and an I/O write.
        fetch(16'h0000, 8'hDD);
        fetch(16'h0001, 8'h29);
        fetch(16'h0002, 8'h3E);
        bus_cycle(1, 3, 16'h0003, 8'h5A, 1); clk_drive(T_IDLE);
        fetch(16'h0004, 8'h32);
        bus_cycle(1, 3, 16'h0005, 8'h34, 1); clk_drive(T_IDLE);
        bus_cycle(1, 3, 16'h0006, 8'h12, 1); clk_drive(T_IDLE);
        bus_cycle(2, 3, 16'h1234, 8'h5A, 1); clk_drive(T_IDLE);
        fetch(16'h0007, 8'hD3);
        bus_cycle(1, 3, 16'h0008, 8'h7F, 1); clk_drive(T_IDLE);
        bus_cycle(4, 4, 16'h5A7F, 8'h5A, 1);
        repeat (4) clk_drive(T_IDLE);

        // Masked cycles are skipped; capture resumes at the next cycle start.
        rec_ready = 0; enable = 0;
        fetch(16'h0010, 8'h00);
        fetch(16'h0011, 8'h01);
        enable = 1;
        fetch(16'h0012, 8'h02);
        chk("t6_level", 32'(level), 1);
        rec_ready = 1;
        repeat (3) clk_drive(T_IDLE);

        // Randomized cycles, back-to-back type changes, enable/ready/clear noise.
        rnd_mode = 1;
        prev = -1;
        nogap = 0;
        repeat (150) begin
            t = $urandom_range(0, 5);
            n = $urandom_range(1, 4);
            if (nogap && t == prev) t = (t + 1) % 6;
            bus_cycle(t, n, 16'($urandom), 8'h00, 0);
            if (t == 0) begin
                clk_drive(T_RFSH);
                clk_drive(T_RFSH);
                nogap = 0;
            end else begin
                g = $urandom_range(0, 2);
                repeat (g) clk_drive(T_IDLE);
                nogap = (g == 0);
            end
            prev = t;
        end
        rnd_mode = 0;
        enable = 1; rec_ready = 1; clr_ovf = 1;
        clk_drive(T_IDLE);
        clr_ovf = 0;
        repeat (12) clk_drive(T_IDLE);

        // Overflow: 10 fetches into an 8-deep FIFO with no consumer.
        rec_ready = 0;
        for (int i = 0; i < 10; i++) fetch(16'(16'h0100 + i), 8'(8'hA0 + i));
        chk("t3_level", 32'(level), 8);
        chk("t3_overflow", 32'(overflow), 1);
        chk("t3_drop_cnt", 32'(drop_cnt), 2);
        clr_ovf = 1;
        clk_drive(T_IDLE);
        clr_ovf = 0;
        chk("t3_clr_overflow", 32'(overflow), 0);
        chk("t3_clr_drop_cnt", 32'(drop_cnt), 0);

        // Full FIFO, pop lands on the push edge: nothing dropped.
        bus_cycle(0, 2, 16'h0200, 8'hB0, 1);
        clk_drive(T_RFSH);
        rec_ready = 1;
        clk_drive(T_RFSH);
        rec_ready = 0;
        chk("t4_level", 32'(level), 8);
        chk("t4_drop_cnt", 32'(drop_cnt), 0);
        rec_ready = 1;
        repeat (10) clk_drive(T_IDLE);

        // Reset mid-fetch: cut cycle discarded, next full cycle recorded.
        rec_ready = 0;
        drive(0); A = 16'h0300; step();
        reset = 1; step();
        chk("t5_level", 32'(level), 0);
        chk("t5_rec_valid", 32'(rec_valid), 0);
        chk("t5_rec_addr", 32'(rec_addr), 0);
        reset = 0;
        step();
        step();
        clk_drive(T_IDLE);
        fetch(16'h0301, 8'hAA);
        chk("t5_level_after", 32'(level), 1);
        chk("t5_rec_data", 32'(rec_data), 32'h00AA);

        // Drop counter saturation, then a clear colliding with a drop.
        for (int i = 0; i < 270; i++) begin
            bus_cycle(0, 1, 16'(i), 8'(i), 1);
            clk_drive(T_RFSH);
        end
        clk_drive(T_IDLE);
        chk("sat_drop_cnt", 32'(drop_cnt), 255);
        chk("sat_overflow", 32'(overflow), 1);
        bus_cycle(0, 1, 16'h0400, 8'hCC, 1);
        clk_drive(T_RFSH);
        clr_ovf = 1;
        clk_drive(T_IDLE);
        clr_ovf = 0;
        chk("clrdrop_overflow", 32'(overflow), 1);
        chk("clrdrop_drop_cnt", 32'(drop_cnt), 1);
        clr_ovf = 1;
        clk_drive(T_IDLE);
        clr_ovf = 0;
        chk("clr_drop_cnt", 32'(drop_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
